// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM encoding and default timing for the button reader.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_WAIT = 3'd1,
    HELD       = 3'd2,
    LONG_HELD  = 3'd3,
    REL_WAIT   = 3'd4
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The raw input feeds the first flop directly, with no logic in front of it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced active-low pushbutton reader with pulses, long-press and press counter.
module button_reader
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_n,
  input  logic             i_clr_count,
  output logic             o_pressed,
  output logic             o_press_pulse,
  output logic             o_rel_pulse,
  output logic             o_long_press,
  output logic [CNT_W-1:0] o_press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic btn_sync_n;
  logic s_btn;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              from_long_q, from_long_d;
  logic              pressed_q, pressed_d;
  logic              press_pulse_q, press_pulse_d;
  logic              rel_pulse_q, rel_pulse_d;
  logic              long_q, long_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_base;
  logic              commit;

  // Resets to "released" so a button held through reset shows up as a fresh press.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_btn_n),
    .q_o   (btn_sync_n)
  );

  assign s_btn = ~btn_sync_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      from_long_q   <= 1'b0;
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
      rel_pulse_q   <= 1'b0;
      long_q        <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      from_long_q   <= from_long_d;
      pressed_q     <= pressed_d;
      press_pulse_q <= press_pulse_d;
      rel_pulse_q   <= rel_pulse_d;
      long_q        <= long_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    from_long_d   = from_long_q;
    pressed_d     = pressed_q;
    long_d        = long_q;
    press_pulse_d = 1'b0;
    rel_pulse_d   = 1'b0;
    commit        = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_btn) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s_btn) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = HELD;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          hold_cnt_d    = '0;
          commit        = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        // A pending release takes priority over reaching the long-press threshold.
        if (!s_btn) begin
          state_d     = REL_WAIT;
          db_cnt_d    = DB_W'(1);
          from_long_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!s_btn) begin
          state_d     = REL_WAIT;
          db_cnt_d    = DB_W'(1);
          from_long_d = 1'b1;
        end
      end
      REL_WAIT: begin
        if (s_btn) begin
          state_d  = from_long_q ? LONG_HELD : HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          db_cnt_d    = '0;
          pressed_d   = 1'b0;
          long_d      = 1'b0;
          rel_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear coinciding with a commit still counts that press.
    count_base = i_clr_count ? '0 : count_q;
    count_d    = commit ? count_base + CNT_W'(1) : count_base;
  end

  assign o_pressed     = pressed_q;
  assign o_press_pulse = press_pulse_q;
  assign o_rel_pulse   = rel_pulse_q;
  assign o_long_press  = long_q;
  assign o_press_count = count_q;

endmodule
